// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller: fetch/decode/execute sequencing with memory
// wait handling, illegal-op flagging and a retired-instruction counter.
//
// state  | meaning
// FETCH  | read instruction at PC, wait for memory, load IR and PC+4
// DECODE | register read, PC+8 on the ALU, dispatch by op class
// MEMADR | compute load/store address
// MEMRD  | load data read, wait for memory
// MEMWB  | write loaded data to the register file
// MEMWR  | store data write, wait for memory
// EXER   | ALU op with register operand 2
// EXEI   | ALU op with immediate operand 2
// ALUWB  | write ALU result to the register file
// BRANCH | load branch target into PC
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  op,
  input  logic        imm,
  input  logic        load,
  input  logic        cond_ok,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic        alu_op,
  output logic        illegal,
  output logic [15:0] retired,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXER   = 4'd6,
    S_EXEI   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic        run_q;
  logic [15:0] retired_q, retired_d;
  logic        retire;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    if (!run_q) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          if (!cond_ok) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            case (op)
              2'b00:   state_d = imm ? S_EXEI : S_EXER;
              2'b01:   state_d = S_MEMADR;
              2'b10:   state_d = S_BRANCH;
              default: state_d = S_FETCH;
            endcase
          end
        end
        S_MEMADR: state_d = load ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
        S_MEMWR: begin
          if (mem_ready) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
        S_EXER, S_EXEI: state_d = S_ALUWB;
        S_MEMWB, S_ALUWB, S_BRANCH: begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
    retired_d = retire ? retired_q + 16'd1 : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      run_q     <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      retired_q <= retired_d;
    end
  end

  // Control outputs decode straight from the state register so that reset
  // clears them asynchronously; FETCH strobes and illegal also see inputs.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    result_src = 2'd0;
    alu_op     = 1'b0;
    illegal    = 1'b0;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_a  = 1'b1;
          alu_src_b  = 2'd2;
          result_src = 2'd2;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          illegal   = cond_ok && (op == 2'b11);
        end
        S_EXER: alu_op = 1'b1;
        S_EXEI: begin
          alu_src_b = 2'd1;
          alu_op    = 1'b1;
        end
        S_ALUWB: reg_write = 1'b1;
        S_MEMADR: alu_src_b = 2'd1;
        S_MEMRD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = 2'd1;
          reg_write  = 1'b1;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_b  = 2'd1;
          result_src = 2'd2;
          pc_write   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule
